// File: rtl/data_mem_responder.sv
// Serial load/store responder in front of a word RAM.
// Each request waits WAIT_CYCLES, is checked for errors, then responds.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, wr_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] ram_q [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic              bad;
  logic              access;
  logic              ram_we;
  logic              accept;

  assign idx    = addr_q[ADDR_W+1:2];
  assign bad    = (addr_q[1:0] != 2'b00)
               || ((addr_q >> (ADDR_W + 2)) != 32'd0)
               || (rd_q == wr_q);
  assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign ram_we = access && !bad && wr_q;
  assign accept = (state_q == S_IDLE) && req_valid;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = bad;
          rdata_d = (bad || wr_q) ? '0 : ram_q[idx];
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are only meaningful from accept to the access edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (wait 2 and wait 0)
// checked every cycle against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  logic clk_en = 1'b0;

  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       mem_read;
  logic [1:0]       mem_write;
  logic [1:0][31:0] mem_addr;
  logic [1:0][31:0] mem_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 if (clk_en) clk = ~clk;

  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Transaction-level model: busy flag, edges since accept, word memory.
  bit        busy [2];
  int        n    [2];
  bit        q_rd [2];
  bit        q_wr [2];
  bit [31:0] q_a  [2];
  bit [31:0] q_wd [2];
  bit [31:0] e_rd [2];
  bit        e_err[2];
  bit        e_kn [2];
  bit [31:0] mmem [int];

  function automatic int wc(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void mdl_access(int i);
    int key;
    key = i * 4096 + int'(q_a[i] >> 2);
    e_kn[i] = 1'b1;
    e_rd[i] = 32'h0;
    e_err[i] = (q_a[i][1:0] != 2'b00) || (q_a[i] >= 32'h400)
            || (q_rd[i] == q_wr[i]);
    if (!e_err[i]) begin
      if (q_wr[i]) mmem[key] = q_wd[i];
      else if (mmem.exists(key)) e_rd[i] = mmem[key];
      else e_kn[i] = 1'b0;
    end
  endfunction

  function automatic void mdl_step(int i);
    if (rst[i]) begin
      busy[i] = 1'b0;
    end else if (!busy[i]) begin
      if (req_valid[i]) begin
        busy[i] = 1'b1;
        n[i]    = 0;
        q_rd[i] = mem_read[i];
        q_wr[i] = mem_write[i];
        q_a[i]  = mem_addr[i];
        q_wd[i] = mem_wdata[i];
      end
    end else if (n[i] >= wc(i) + 1) begin
      if (rsp_ready[i]) busy[i] = 1'b0;
    end else begin
      if (n[i] == wc(i)) mdl_access(i);
      n[i]++;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) mdl_step(i);
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit v;
      v = busy[i] && (n[i] >= wc(i) + 1);
      chk($sformatf("u%0d req_ready", i), 32'(req_ready[i]), 32'(!busy[i]));
      chk($sformatf("u%0d rsp_valid", i), 32'(rsp_valid[i]), 32'(v));
      if (v) begin
        chk($sformatf("u%0d rsp_err", i), 32'(rsp_err[i]), 32'(e_err[i]));
        if (e_kn[i])
          chk($sformatf("u%0d rsp_rdata", i), rsp_rdata[i], e_rd[i]);
      end
    end
  end

  task automatic xact(input int i, input bit rd, input bit wr,
                      input bit [31:0] a, input bit [31:0] wd,
                      input int hold, output bit [31:0] rdat,
                      output bit err, output int lat);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    mem_read[i]  = rd;
    mem_write[i] = wr;
    mem_addr[i]  = a;
    mem_wdata[i] = wd;
    rsp_ready[i] = (hold == 0);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    mem_addr[i]  = $urandom;
    mem_wdata[i] = $urandom;
    lat = 0;
    while (!rsp_valid[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) chk($sformatf("u%0d rsp timeout", i), 32'(rsp_valid[i]), 32'd1);
    rdat = rsp_rdata[i];
    err  = rsp_err[i];
    for (int h = 0; h < hold; h++) begin
      req_valid[i] = 1'b1;
      mem_read[i]  = 1'b1;
      mem_write[i] = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b0;
  endtask

  task automatic do_reset(input int i);
    #2;
    rst[i]  = 1'b1;
    busy[i] = 1'b0;
    #1;
    chk($sformatf("u%0d rst req_ready", i), 32'(req_ready[i]), 32'd1);
    chk($sformatf("u%0d rst rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
    chk($sformatf("u%0d rst rsp_rdata", i), rsp_rdata[i], 32'h0);
    chk($sformatf("u%0d rst rsp_err", i), 32'(rsp_err[i]), 32'd0);
    @(negedge clk); #1;
    rst[i] = 1'b0;
  endtask

  task automatic directed(input int i);
    bit [31:0] r;
    bit        e;
    int        l;
    int        el;
    string     p;
    p  = $sformatf("u%0d ", i);
    el = (i == 0) ? 3 : 1;
    xact(i, 0, 1, 32'h10, 32'hDEADBEEF, 0, r, e, l);
    chk({p, "st lat"}, l, el);
    chk({p, "st rdata"}, r, 32'h0);
    chk({p, "st err"}, 32'(e), 32'd0);
    xact(i, 1, 0, 32'h10, 32'h0, 0, r, e, l);
    chk({p, "ld lat"}, l, el);
    chk({p, "ld rdata"}, r, 32'hDEADBEEF);
    chk({p, "ld err"}, 32'(e), 32'd0);
    xact(i, 1, 0, 32'h13, 32'h0, 0, r, e, l);
    chk({p, "misal err"}, 32'(e), 32'd1);
    chk({p, "misal rdata"}, r, 32'h0);
    xact(i, 1, 0, 32'h400, 32'h0, 0, r, e, l);
    chk({p, "oor err"}, 32'(e), 32'd1);
    chk({p, "oor rdata"}, r, 32'h0);
    xact(i, 1, 0, 32'h10, 32'h0, 1, r, e, l);
    chk({p, "reld rdata"}, r, 32'hDEADBEEF);
    xact(i, 1, 1, 32'h20, 32'h1, 0, r, e, l);
    chk({p, "both err"}, 32'(e), 32'd1);
    xact(i, 0, 0, 32'h20, 32'h1, 0, r, e, l);
    chk({p, "none err"}, 32'(e), 32'd1);
    xact(i, 1, 0, 32'h20, 32'h0, 5, r, e, l);
    chk({p, "prior rdata"}, r, 32'hC0DE0008);
    chk({p, "prior err"}, 32'(e), 32'd0);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    mem_read[i]  = 1'b0;
    mem_write[i] = 1'b1;
    mem_addr[i]  = 32'h30;
    mem_wdata[i] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    do_reset(i);
    xact(i, 1, 0, 32'h30, 32'h0, 0, r, e, l);
    chk({p, "rst old rdata"}, r, 32'hC0DE000C);
  endtask

  task automatic rand_run(input int i);
    bit [31:0] r;
    bit        e;
    int        l;
    bit        rd;
    bit        wr;
    bit [31:0] a;
    int        op;
    int        sel;
    for (int k = 0; k < 150; k++) begin
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      rd  = (op < 4) || (op == 8);
      wr  = (op >= 4 && op < 8) || (op == 8);
      if (sel < 7) a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h400 << $urandom_range(0, 21);
      else a = 32'($urandom_range(0, 255)) << 2;
      xact(i, rd, wr, a, $urandom, $urandom_range(0, 3) == 0 ? 2 : 0, r, e, l);
    end
  endtask

  task automatic preload(input int i);
    bit [31:0] r;
    bit        e;
    int        l;
    for (int k = 0; k < 16; k++)
      xact(i, 0, 1, 32'(k * 4), 32'hC0DE0000 | 32'(k), 0, r, e, l);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0;
      n[i]    = 0;
    end
    rst       = 2'b00;
    req_valid = 2'b00;
    mem_read  = 2'b00;
    mem_write = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_ready = 2'b00;
    #3;
    rst = 2'b11;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d por req_ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("u%0d por rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("u%0d por rsp_rdata", i), rsp_rdata[i], 32'h0);
      chk($sformatf("u%0d por rsp_err", i), 32'(rsp_err[i]), 32'd0);
    end
    #2;
    rst = 2'b00;
    #2;
    clk_en = 1'b1;
    fork
      preload(0);
      preload(1);
    join
    fork
      directed(0);
      directed(1);
    join
    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
